flag_register: RTL and testbench

- Producer side of the condition-check interface: owns the architectural NZCV flags that the condition checker consumes.
- Takes ALU flags from execute and gates each write by per-group write enables and the instruction's CondEx.
- Holds one write in a pending (commit) stage and forwards it to the checker.
- Keeps a shadow stack of flag snapshots for exception entry and return.

---
 rtl/flag_register_if.sv | 30 +++
 rtl/flag_register.sv | 96 +++++++++
 tb/tb_flag_register.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_register_if.sv
// Condition-check bus between execute and flag_register: flag writes, stack control and flag outputs.
// master drives the execute-side controls; slave is the flag register itself.
interface flag_register_if #(
    parameter int SHADOW_DEPTH = 4,
    parameter int CNT_W        = $clog2(SHADOW_DEPTH + 1)
);
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             CondEx;
    logic             Stall;
    logic             Flush;
    logic             Save;
    logic             Restore;
    logic [3:0]       Flags;
    logic [3:0]       FlagsFwd;
    logic [CNT_W-1:0] ShadowCount;
    logic             Overflow;
    logic             Underflow;
    logic             SeqErr;

    modport master (
        output ALUFlags, FlagW, CondEx, Stall, Flush, Save, Restore,
        input  Flags, FlagsFwd, ShadowCount, Overflow, Underflow, SeqErr
    );

    modport slave (
        input  ALUFlags, FlagW, CondEx, Stall, Flush, Save, Restore,
        output Flags, FlagsFwd, ShadowCount, Overflow, Underflow, SeqErr
    );
endinterface

// File: rtl/flag_register.sv
// NZCV flag register with one pending commit stage and a LIFO shadow stack for exception entry/return.
// Define FLAGREG_FWD_EN to bypass the pending write onto FlagsFwd and into saved snapshots.
module flag_register #(
    parameter int SHADOW_DEPTH = 4,
    parameter int CNT_W        = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    flag_register_if.slave bus
);
    localparam int IDX_W = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

    logic [3:0]       flags_q, flags_d;
    logic             pend_valid_q, pend_valid_d;
    logic [3:0]       pend_mask_q, pend_data_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, underflow_q, seq_err_q;
    logic [3:0]       shadow_q [SHADOW_DEPTH];

    logic [3:0]       merged, push_val, top_entry;
    logic             save_eff, restore_eff, full, empty, do_push, do_pop;
    logic [IDX_W-1:0] push_idx, top_idx;

    always_comb begin
        merged      = pend_valid_q ? ((flags_q & ~pend_mask_q) | (pend_data_q & pend_mask_q)) : flags_q;
        save_eff    = bus.Save & ~bus.Restore & ~bus.Stall;
        restore_eff = bus.Restore & ~bus.Save & ~bus.Stall;
        full        = (count_q == CNT_W'(SHADOW_DEPTH));
        empty       = (count_q == '0);
        do_push     = save_eff & ~full;
        do_pop      = restore_eff & ~empty;
        push_idx    = IDX_W'(count_q);
        top_idx     = IDX_W'(count_q - CNT_W'(1));
        top_entry   = shadow_q[top_idx];
`ifdef FLAGREG_FWD_EN
        push_val    = merged;
`else
        push_val    = flags_q;
`endif
        // A successful pop overrides the pending commit and blocks this cycle's capture.
        flags_d      = do_pop ? top_entry : merged;
        pend_valid_d = bus.CondEx & (|bus.FlagW) & ~bus.Flush & ~do_pop;
        count_d      = count_q;
        if (do_push) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q      <= 4'b0000;
            pend_valid_q <= 1'b0;
            pend_mask_q  <= 4'b0000;
            pend_data_q  <= 4'b0000;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            seq_err_q <= bus.Save & bus.Restore & ~bus.Stall;
            if (!bus.Stall) begin
                flags_q      <= flags_d;
                pend_valid_q <= pend_valid_d;
                pend_mask_q  <= {bus.FlagW[1], bus.FlagW[1], bus.FlagW[0], bus.FlagW[0]};
                pend_data_q  <= bus.ALUFlags;
                count_q      <= count_d;
                if (save_eff && full) begin
                    overflow_q <= 1'b1;
                end
                if (restore_eff && empty) begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    // Stack contents are don't-care after reset, so the storage carries no reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            shadow_q[push_idx] <= push_val;
        end
    end

    assign bus.Flags       = flags_q;
`ifdef FLAGREG_FWD_EN
    assign bus.FlagsFwd    = merged;
`else
    assign bus.FlagsFwd    = flags_q;
`endif
    assign bus.ShadowCount = count_q;
    assign bus.Overflow    = overflow_q;
    assign bus.Underflow   = underflow_q;
    assign bus.SeqErr      = seq_err_q;
endmodule

// File: tb/tb_flag_register.sv
// Directed and randomized bench for flag_register against a queue-based behavioural model.
// Honours FLAGREG_FWD_EN the same way the design does.
module tb_flag_register;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flag_register_if #(.SHADOW_DEPTH(DEPTH)) bus ();
    flag_register #(.SHADOW_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural model: architectural flags, one optional pending write, stack as a queue.
    logic [3:0] m_flags;
    logic       m_pv;
    logic [3:0] m_pm, m_pd;
    logic [3:0] m_stk[$];
    logic       m_ovf, m_unf, m_seq;

    function automatic logic [3:0] m_merged();
        return m_pv ? ((m_flags & ~m_pm) | (m_pd & m_pm)) : m_flags;
    endfunction

    function automatic logic [3:0] m_fwd();
`ifdef FLAGREG_FWD_EN
        return m_merged();
`else
        return m_flags;
`endif
    endfunction

    task automatic model_step();
        logic [3:0] mg;
        logic       pop;
        mg = m_merged();
        if (!rst_n) begin
            m_flags = 4'b0; m_pv = 1'b0; m_pm = 4'b0; m_pd = 4'b0;
            m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_seq = 1'b0;
        end else if (bus.Stall) begin
            m_seq = 1'b0;
        end else begin
            m_seq = bus.Save & bus.Restore;
            pop   = 1'b0;
            if (bus.Save && !bus.Restore) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(m_fwd());
                else m_ovf = 1'b1;
            end
            if (bus.Restore && !bus.Save) begin
                if (m_stk.size() > 0) pop = 1'b1;
                else m_unf = 1'b1;
            end
            m_flags = pop ? m_stk.pop_back() : mg;
            m_pv = !pop && bus.CondEx && (bus.FlagW != 2'b00) && !bus.Flush;
            m_pm = {bus.FlagW[1], bus.FlagW[1], bus.FlagW[0], bus.FlagW[0]};
            m_pd = bus.ALUFlags;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.ALUFlags = 4'b0; bus.FlagW = 2'b00; bus.CondEx = 1'b0; bus.Stall = 1'b0;
        bus.Flush = 1'b0; bus.Save = 1'b0; bus.Restore = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write(input logic [3:0] v, input logic [1:0] w, input logic ce);
        idle();
        bus.ALUFlags = v; bus.FlagW = w; bus.CondEx = ce;
        tick();
        idle();
    endtask

    task automatic test_reset();
        write(4'b1111, 2'b11, 1'b1);
        do_reset();
        checks++;
        if (bus.Flags !== 4'b0000 || bus.FlagsFwd !== 4'b0000 || bus.ShadowCount !== CW'(0) ||
            bus.Overflow !== 1'b0 || bus.Underflow !== 1'b0 || bus.SeqErr !== 1'b0) begin
            errors++;
            $display("FAIL reset: got Flags=%b Fwd=%b Cnt=%0d O=%b U=%b S=%b required 0000 0000 0 0 0 0",
                     bus.Flags, bus.FlagsFwd, bus.ShadowCount, bus.Overflow, bus.Underflow, bus.SeqErr);
        end
        // Reset arriving with a pending write must drop it.
        tick();
        checks++;
        if (bus.Flags !== 4'b0000) begin
            errors++; $display("FAIL reset_pending: got Flags=%b required 0000", bus.Flags);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_write();
        do_reset();
        write(4'b1010, 2'b11, 1'b1);
        checks++;
        if (bus.Flags !== 4'b0000 || bus.FlagsFwd !== m_fwd()) begin
            errors++; $display("FAIL basic_lat1: got Flags=%b Fwd=%b required 0000 %b", bus.Flags, bus.FlagsFwd, m_fwd());
        end
        tick();
        checks++;
        if (bus.Flags !== 4'b1010 || bus.FlagsFwd !== 4'b1010) begin
            errors++; $display("FAIL basic_lat2: got Flags=%b Fwd=%b required 1010 1010", bus.Flags, bus.FlagsFwd);
        end
        $display("test_basic_write done");
    endtask

    task automatic test_group_mask();
        write(4'b0101, 2'b01, 1'b1);
        tick();
        checks++;
        if (bus.Flags !== 4'b1001) begin
            errors++; $display("FAIL mask_cv: got Flags=%b required 1001", bus.Flags);
        end
        write(4'b0110, 2'b00, 1'b1);
        tick();
        write(4'b0110, 2'b11, 1'b0);
        tick();
        checks++;
        if (bus.Flags !== 4'b1001 || bus.FlagsFwd !== 4'b1001) begin
            errors++; $display("FAIL mask_none: got Flags=%b Fwd=%b required 1001", bus.Flags, bus.FlagsFwd);
        end
        write(4'b0110, 2'b10, 1'b1);
        tick();
        checks++;
        if (bus.Flags !== 4'b0101) begin
            errors++; $display("FAIL mask_nz: got Flags=%b required 0101", bus.Flags);
        end
        $display("test_group_mask done");
    endtask

    task automatic test_stall_flush();
        do_reset();
        write(4'b0110, 2'b11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.Stall = 1'b1; bus.ALUFlags = 4'($urandom); bus.FlagW = 2'b11; bus.CondEx = 1'b1;
            bus.Flush = 1'b1;
            tick();
            checks++;
            if (bus.Flags !== 4'b0000 || bus.FlagsFwd !== m_fwd()) begin
                errors++; $display("FAIL stall_hold%0d: got Flags=%b Fwd=%b required 0000 %b", i, bus.Flags, bus.FlagsFwd, m_fwd());
            end
        end
        idle();
        tick();
        checks++;
        if (bus.Flags !== 4'b0110) begin
            errors++; $display("FAIL stall_release: got Flags=%b required 0110", bus.Flags);
        end
        bus.ALUFlags = 4'b1111; bus.FlagW = 2'b11; bus.CondEx = 1'b1; bus.Flush = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (bus.Flags !== 4'b0110 || bus.FlagsFwd !== 4'b0110) begin
            errors++; $display("FAIL flush_drop: got Flags=%b Fwd=%b required 0110", bus.Flags, bus.FlagsFwd);
        end
        $display("test_stall_flush done");
    endtask

    task automatic test_shadow_stack();
        logic [3:0] vals [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                write(vals[i], 2'b11, 1'b1);
                tick();
            end
            bus.Save = 1'b1;
            tick();
            idle();
            checks++;
            if (bus.ShadowCount !== CW'((i < 4) ? i + 1 : 4) || bus.Overflow !== (i == 4)) begin
                errors++; $display("FAIL save%0d: got Cnt=%0d O=%b required %0d %b", i, bus.ShadowCount, bus.Overflow,
                                   (i < 4) ? i + 1 : 4, i == 4);
            end
        end
        for (int i = 0; i < 5; i++) begin
            bus.Restore = 1'b1;
            tick();
            idle();
            checks++;
            if (bus.Flags !== vals[(i < 4) ? 3 - i : 0] || bus.Underflow !== (i == 4) ||
                bus.ShadowCount !== CW'((i < 4) ? 3 - i : 0)) begin
                errors++; $display("FAIL restore%0d: got Flags=%b U=%b Cnt=%0d required %b %b %0d", i, bus.Flags,
                                   bus.Underflow, bus.ShadowCount, vals[(i < 4) ? 3 - i : 0], i == 4, (i < 4) ? 3 - i : 0);
            end
        end
        $display("test_shadow_stack done");
    endtask

    task automatic test_restore_vs_pending();
        do_reset();
        write(4'b0011, 2'b11, 1'b1);
        tick();
        bus.Save = 1'b1;
        tick();
        write(4'b1111, 2'b11, 1'b1);
        bus.Restore = 1'b1;
        bus.ALUFlags = 4'b1100; bus.FlagW = 2'b11; bus.CondEx = 1'b1;
        tick();
        idle();
        checks++;
        if (bus.Flags !== 4'b0011 || bus.FlagsFwd !== 4'b0011 || bus.ShadowCount !== CW'(0)) begin
            errors++; $display("FAIL restore_pend: got Flags=%b Fwd=%b Cnt=%0d required 0011 0011 0", bus.Flags, bus.FlagsFwd, bus.ShadowCount);
        end
        tick();
        checks++;
        if (bus.Flags !== 4'b0011) begin
            errors++; $display("FAIL restore_nocap: got Flags=%b required 0011", bus.Flags);
        end
        $display("test_restore_vs_pending done");
    endtask

    task automatic test_seq_err();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            write(4'($urandom), 2'b11, 1'b1);
            bus.Save = 1'b1;
            tick();
            idle();
        end
        bus.Save = 1'b1; bus.Restore = 1'b1;
        bus.ALUFlags = 4'b1001; bus.FlagW = 2'b11; bus.CondEx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            checks++;
            if (bus.SeqErr !== (i == 0) || bus.ShadowCount !== CW'(2) || bus.Flags !== m_flags ||
                bus.FlagsFwd !== m_fwd()) begin
                errors++; $display("FAIL seqerr%0d: got S=%b Cnt=%0d Flags=%b Fwd=%b required %b 2 %b %b", i, bus.SeqErr,
                                   bus.ShadowCount, bus.Flags, bus.FlagsFwd, i == 0, m_flags, m_fwd());
            end
        end
        $display("test_seq_err done");
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n        = ($urandom_range(0, 99) >= 2);
            bus.ALUFlags = 4'($urandom);
            bus.FlagW    = 2'($urandom);
            bus.CondEx   = ($urandom_range(0, 99) < 70);
            bus.Stall    = ($urandom_range(0, 99) < 20);
            bus.Flush    = ($urandom_range(0, 99) < 15);
            bus.Save     = ($urandom_range(0, 99) < 20);
            bus.Restore  = ($urandom_range(0, 99) < 20);
            tick();
            checks++;
            if (bus.Flags !== m_flags || bus.FlagsFwd !== m_fwd() || bus.ShadowCount !== CW'(m_stk.size()) ||
                bus.Overflow !== m_ovf || bus.Underflow !== m_unf || bus.SeqErr !== m_seq) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random%0d: got F=%b Fwd=%b C=%0d O=%b U=%b S=%b required %b %b %0d %b %b %b", i,
                             bus.Flags, bus.FlagsFwd, bus.ShadowCount, bus.Overflow, bus.Underflow, bus.SeqErr,
                             m_flags, m_fwd(), m_stk.size(), m_ovf, m_unf, m_seq);
                bad++;
            end
        end
        rst_n = 1'b1;
        idle();
        $display("test_random done");
    endtask

    initial begin
        idle();
        test_reset();
        test_basic_write();
        test_group_mask();
        test_stall_flush();
        test_shadow_stack();
        test_restore_vs_pending();
        test_seq_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
